register_file: RTL and testbench

- Parameterised multi-port integer register file for the RV64 datapath: two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Register 0 is hardwired to zero.
- Sits between decode (register addresses) and execute/writeback (operands, result write-back).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 22 ++
 rtl/register_file.sv | 73 +++++++
 tb/tb_register_file.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the RV64 integer register file.
package regfile_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index -> data, with index 0 and out-of-range indices reading 0.
module regfile_read_port #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NumRegs    = 32,
  parameter int unsigned IndexWidth = $clog2(NumRegs)
) (
  input  logic [IndexWidth-1:0]             i_addr,
  input  logic [NumRegs-1:1][DataWidth-1:0] i_regs,
  output logic [DataWidth-1:0]              o_data
);

  // Index 0 and indices >= NumRegs never match, so they fall through to the zero default.
  always_comb begin
    o_data = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      if (i_addr == IndexWidth'(i)) begin
        o_data = i_regs[i];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DataWidth  = XLEN,
  parameter int unsigned NumRegs    = NREGS,
  parameter int unsigned IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEn,
  input  logic [DataWidth-1:0]  writeData,
  input  logic [IndexWidth-1:0] writeAddr,
  input  logic [IndexWidth-1:0] readAddr1,
  input  logic [IndexWidth-1:0] readAddr2,
  output logic [DataWidth-1:0]  readData1,
  output logic [DataWidth-1:0]  readData2
);

  logic [DataWidth-1:0]              r_regs [1:NumRegs-1];
  logic [NumRegs-1:1]                w_wr_sel;
  logic [NumRegs-1:1][DataWidth-1:0] w_regs;

  // Write decoder: index 0 and out-of-range indices select nothing.
  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      w_wr_sel[i] = writeEn && (writeAddr == IndexWidth'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        if (w_wr_sel[i]) begin
          r_regs[i] <= writeData;
        end
      end
    end
  end

  always_comb begin
    w_regs = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  regfile_read_port #(
    .DataWidth  (DataWidth),
    .NumRegs    (NumRegs),
    .IndexWidth (IndexWidth)
  ) u_rd1 (
    .i_addr (readAddr1),
    .i_regs (w_regs),
    .o_data (readData1)
  );

  regfile_read_port #(
    .DataWidth  (DataWidth),
    .NumRegs    (NumRegs),
    .IndexWidth (IndexWidth)
  ) u_rd2 (
    .i_addr (readAddr2),
    .i_regs (w_regs),
    .o_data (readData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: scoreboard of expected read values against a reference array.
module tb_register_file;
  import regfile_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     writeEn;
  xlen_t    writeData;
  reg_idx_t writeAddr, readAddr1, readAddr2;
  xlen_t    readData1, readData2;

  // Second instance with a non-power-of-2 register count for out-of-range indices.
  logic     b_writeEn;
  xlen_t    b_writeData;
  reg_idx_t b_writeAddr, b_readAddr1, b_readAddr2;
  xlen_t    b_readData1, b_readData2;

  always #5 clk = ~clk;

  register_file u_dut (
    .clk       (clk),
    .rst       (rst),
    .writeEn   (writeEn),
    .writeData (writeData),
    .writeAddr (writeAddr),
    .readAddr1 (readAddr1),
    .readAddr2 (readAddr2),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  register_file #(
    .DataWidth  (64),
    .NumRegs    (24),
    .IndexWidth (5)
  ) u_dut24 (
    .clk       (clk),
    .rst       (rst),
    .writeEn   (b_writeEn),
    .writeData (b_writeData),
    .writeAddr (b_writeAddr),
    .readAddr1 (b_readAddr1),
    .readAddr2 (b_readAddr2),
    .readData1 (b_readData1),
    .readData2 (b_readData2)
  );

  typedef struct {
    string tag;
    int    src;
    xlen_t exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  xlen_t     mdl [32];
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic chk(input string tag, input xlen_t act, input xlen_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int src, input xlen_t exp);
    sb_q.push_back('{tag: tag, src: src, exp: exp});
  endtask

  // Pops every pending expectation and compares it with the port it names.
  task automatic drain();
    sb_entry_t e;
    xlen_t     act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.src)
        0:       act = readData1;
        1:       act = readData2;
        2:       act = b_readData1;
        default: act = b_readData2;
      endcase
      chk(e.tag, act, e.exp);
    end
  endtask

  task automatic rd(input int a1, input int a2, input string tag);
    @(negedge clk);
    readAddr1 = reg_idx_t'(a1);
    readAddr2 = reg_idx_t'(a2);
    expect_rd($sformatf("%s_p1_i%0d", tag, a1), 0, mdl[a1]);
    expect_rd($sformatf("%s_p2_i%0d", tag, a2), 1, mdl[a2]);
    #1 drain();
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) rd(i, 31 - i, tag);
  endtask

  task automatic wr(input int idx, input xlen_t data, input logic en);
    @(negedge clk);
    writeAddr = reg_idx_t'(idx);
    writeData = data;
    writeEn   = en;
    @(posedge clk);
    #1 writeEn = 1'b0;
    if (en && idx != 0) mdl[idx] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  initial begin
    rst = 1'b0; writeEn = 1'b0; writeData = '0; writeAddr = '0;
    readAddr1 = '0; readAddr2 = '0;
    b_writeEn = 1'b0; b_writeData = '0; b_writeAddr = '0;
    b_readAddr1 = '0; b_readAddr2 = '0;

    // x0 reads zero even before any reset.
    #2;
    expect_rd("prereset_x0_p1", 0, 64'h0);
    expect_rd("prereset_x0_p2", 1, 64'h0);
    expect_rd("prereset_x0_b", 2, 64'h0);
    drain();

    do_reset();
    sweep("reset");

    for (int i = 1; i < 32; i++) wr(i, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    sweep("ones");

    wr(0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    rd(0, 0, "x0_write");

    wr(5, 64'h1234, 1'b0);
    rd(5, 5, "we0");

    // Read-during-write: old value before the edge, new value after.
    @(negedge clk);
    writeAddr = 5'd5; writeData = 64'h1234; writeEn = 1'b1;
    readAddr1 = 5'd5; readAddr2 = 5'd5;
    #1;
    expect_rd("rdw_before", 0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    @(posedge clk);
    #1 writeEn = 1'b0;
    expect_rd("rdw_after_p1", 0, 64'h1234);
    expect_rd("rdw_after_p2", 1, 64'h1234);
    drain();
    mdl[5] = 64'h1234;

    for (int i = 0; i < 32; i++) wr(i, xlen_t'(i) * 64'h0101, 1'b1);
    @(negedge clk);
    readAddr1 = 5'd7; readAddr2 = 5'd31;
    expect_rd("distinct_7", 0, 64'h0707);
    expect_rd("distinct_31", 1, 64'h1F1F);
    #1 drain();
    sweep("distinct");

    // Reset wins over a simultaneous write.
    @(negedge clk);
    rst = 1'b1; writeEn = 1'b1; writeAddr = 5'd3; writeData = 64'hAAAA;
    @(posedge clk);
    #1 rst = 1'b0; writeEn = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    sweep("rst_vs_we");

    // 24-entry instance: writes to index >= 24 are dropped, reads there return 0.
    @(negedge clk);
    b_writeAddr = 5'd23; b_writeData = 64'h55; b_writeEn = 1'b1;
    @(negedge clk);
    b_writeAddr = 5'd25; b_writeData = 64'h77;
    @(negedge clk);
    b_writeEn = 1'b0;
    b_readAddr1 = 5'd23; b_readAddr2 = 5'd25;
    expect_rd("n24_idx23", 2, 64'h55);
    expect_rd("n24_idx25", 3, 64'h0);
    #1 drain();
    @(negedge clk);
    b_readAddr1 = 5'd31; b_readAddr2 = 5'd0;
    expect_rd("n24_idx31", 2, 64'h0);
    expect_rd("n24_idx0", 3, 64'h0);
    #1 drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
